// File: rtl/skewed_mem_array_pkg.sv
`default_nettype none
// ============================================================================
// Module      : skewed_mem_array_pkg
// Description : Shared defaults and lane-slicing helper for the skewed banked
//               scratch memory and its address sequencers.
// Revision    : 1.0 - initial release
// ============================================================================
package skewed_mem_array_pkg;

    localparam int unsigned WIDTH_HEIGHT_DEF = 16;
    localparam int unsigned DATA_W_DEF       = 8;
    localparam int unsigned ADDR_W_DEF       = 8;

    // LSB position of lane 'lane' inside a flat bus of 'w'-bit lanes.
    function automatic int unsigned lane_lsb(input int unsigned lane,
                                             input int unsigned w);
        return lane * w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/skewed_mem_array_skew_addr_seq.sv
`default_nettype none
// ============================================================================
// Module      : skew_addr_seq
// Description : Row sequencer with a diagonal skew. A wrapping row counter
//               feeds lane 0; every further lane is a one-cycle delayed copy
//               of its neighbour, so lane k lags 'active' by 1+k cycles.
// Ports       : clk_i    - rising-edge clock
//               rst_ni   - asynchronous active-low reset
//               active_i - sequence runs while high
//               en_o     - per-lane enable (LANES bits)
//               addr_o   - per-lane row address (LANES*ADDR_W bits)
// Revision    : 1.0 - initial release
// ============================================================================
module skew_addr_seq
    import skewed_mem_array_pkg::*;
#(
    parameter int unsigned LANES  = WIDTH_HEIGHT_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    active_i,
    output logic [LANES-1:0]        en_o,
    output logic [LANES*ADDR_W-1:0] addr_o
);

    localparam logic [ADDR_W-1:0] C_LAST_ROW = ADDR_W'(LANES - 1);

    logic [ADDR_W-1:0]       cnt_q;
    logic [ADDR_W-1:0]       cnt_d;
    logic [LANES-1:0]        en_q;
    logic [LANES*ADDR_W-1:0] addr_q;

    // Counter restarts from row 0 whenever the sequence is idle.
    always_comb begin
        cnt_d = '0;
        if (active_i) begin
            cnt_d = (cnt_q == C_LAST_ROW) ? '0 : cnt_q + 1'b1;
        end
    end

    // Lane 0 captures the live counter; higher lanes shift up by one lane
    // per cycle, which produces the diagonal wavefront. The pipeline keeps
    // shifting after 'active' drops so in-flight rows drain completely.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            en_q   <= '0;
            addr_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            en_q   <= {en_q[LANES-2:0], active_i};
            addr_q <= {addr_q[(LANES-1)*ADDR_W-1:0], cnt_q};
        end
    end

    assign en_o   = en_q;
    assign addr_o = addr_q;

endmodule
`default_nettype wire

// File: rtl/skewed_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : skewed_mem_array
// Description : Banked scratch memory between host buffers and a systolic
//               array. WIDTH_HEIGHT independent banks, each driven by a
//               skewed write and read sequencer so rows enter and leave the
//               banks already staggered one cycle per lane.
// Ports       : clk       - rising-edge clock
//               reset     - asynchronous active-low reset
//               wr_active - write sequencer runs while high
//               rd_active - read sequencer runs while high
//               wr_data   - per-lane write data, lane k at [k*DATA_W +: DATA_W]
//               rd_data   - per-lane registered read data
//               wr_en     - per-lane write enable
//               rd_en     - per-lane read enable
//               wr_addr   - per-lane write address
//               rd_addr   - per-lane read address
// Revision    : 1.0 - initial release
// ============================================================================
module skewed_mem_array
    import skewed_mem_array_pkg::*;
#(
    parameter int unsigned WIDTH_HEIGHT = WIDTH_HEIGHT_DEF,
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned DEPTH        = 2**ADDR_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wr_active,
    input  logic                           rd_active,
    input  logic [WIDTH_HEIGHT*DATA_W-1:0] wr_data,
    output logic [WIDTH_HEIGHT*DATA_W-1:0] rd_data,
    output logic [WIDTH_HEIGHT-1:0]        wr_en,
    output logic [WIDTH_HEIGHT-1:0]        rd_en,
    output logic [WIDTH_HEIGHT*ADDR_W-1:0] wr_addr,
    output logic [WIDTH_HEIGHT*ADDR_W-1:0] rd_addr
);

    skew_addr_seq #(
        .LANES  (WIDTH_HEIGHT),
        .ADDR_W (ADDR_W)
    ) u_wr_seq (
        .clk_i    (clk),
        .rst_ni   (reset),
        .active_i (wr_active),
        .en_o     (wr_en),
        .addr_o   (wr_addr)
    );

    skew_addr_seq #(
        .LANES  (WIDTH_HEIGHT),
        .ADDR_W (ADDR_W)
    ) u_rd_seq (
        .clk_i    (clk),
        .rst_ni   (reset),
        .active_i (rd_active),
        .en_o     (rd_en),
        .addr_o   (rd_addr)
    );

    for (genvar k = 0; k < WIDTH_HEIGHT; k++) begin : g_bank
        localparam int unsigned C_DL = lane_lsb(k, DATA_W);
        localparam int unsigned C_AL = lane_lsb(k, ADDR_W);

        logic [DATA_W-1:0] mem_q [DEPTH];
        logic [DATA_W-1:0] rd_data_q;

        // Storage is deliberately not reset; contents survive a reset.
        always_ff @(posedge clk) begin
            if (wr_en[k]) begin
                mem_q[wr_addr[C_AL +: ADDR_W]] <= wr_data[C_DL +: DATA_W];
            end
        end

        // Non-blocking update gives read-first behaviour on a same-address
        // collision: the read sees the word from before this edge's write.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                rd_data_q <= '0;
            end else if (rd_en[k]) begin
                rd_data_q <= mem_q[rd_addr[C_AL +: ADDR_W]];
            end
        end

        assign rd_data[C_DL +: DATA_W] = rd_data_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_skewed_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_skewed_mem_array
// Description : Self-checking bench for skewed_mem_array. A behavioural model
//               logs what the sequencers were asked to do each edge and
//               derives expected lane enables, addresses and read data; a
//               negedge monitor compares against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_skewed_mem_array;

    localparam int WH    = 16;
    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 256;
    localparam int MAXE  = 4096;

    logic             clk       = 1'b0;
    logic             reset     = 1'b0;
    logic             wr_active = 1'b0;
    logic             rd_active = 1'b0;
    logic [WH*DW-1:0] wr_data   = '0;
    logic [WH*DW-1:0] rd_data;
    logic [WH-1:0]    wr_en;
    logic [WH-1:0]    rd_en;
    logic [WH*AW-1:0] wr_addr;
    logic [WH*AW-1:0] rd_addr;

    skewed_mem_array #(
        .WIDTH_HEIGHT (WH),
        .DATA_W       (DW),
        .ADDR_W       (AW),
        .DEPTH        (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_active (wr_active),
        .rd_active (rd_active),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .wr_addr   (wr_addr),
        .rd_addr   (rd_addr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Per edge e (1-based): whether each sequencer was active, and which row
    // its counter held going into that edge (consecutive active edges mod WH).
    // Lane k after edge n shows the request logged at edge n-k.
    int          n_edge   = 0;
    int          rst_edge = 0;
    bit          w_act_log [MAXE];
    int          w_row_log [MAXE];
    bit          r_act_log [MAXE];
    int          r_row_log [MAXE];
    int          w_run    = 0;
    int          r_run    = 0;
    logic [DW-1:0] mdl_mem [WH][DEPTH];
    logic [DW-1:0] exp_rd  [WH] = '{default: '0};
    logic [DW-1:0] rdq     [WH][$];

    function automatic bit log_ok(input int e);
        return (e >= 1) && (e > rst_edge);
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            n_edge++;
            rst_edge = n_edge;
            w_run = 0;
            r_run = 0;
        end else begin
            // reads see memory before this edge's writes
            for (int k = 0; k < WH; k++) begin
                if (log_ok(n_edge - k) && r_act_log[n_edge - k]) begin
                    exp_rd[k] = mdl_mem[k][r_row_log[n_edge - k]];
                    rdq[k].push_back(exp_rd[k]);
                end
            end
            for (int k = 0; k < WH; k++) begin
                if (log_ok(n_edge - k) && w_act_log[n_edge - k])
                    mdl_mem[k][w_row_log[n_edge - k]] = wr_data[k*DW +: DW];
            end
            n_edge++;
            w_act_log[n_edge] = wr_active;
            w_row_log[n_edge] = w_run % WH;
            w_run = wr_active ? w_run + 1 : 0;
            r_act_log[n_edge] = rd_active;
            r_row_log[n_edge] = r_run % WH;
            r_run = rd_active ? r_run + 1 : 0;
        end
    end

    always @(negedge reset) begin
        for (int k = 0; k < WH; k++) begin
            rdq[k].delete();
            exp_rd[k] = '0;
        end
    end

    // ---------------- monitor ----------------
    logic [WH-1:0]    prev_rd_en = '0;
    logic [WH-1:0]    x_wen, x_ren;
    logic [WH*AW-1:0] x_wad, x_rad;
    logic [WH*DW-1:0] x_rd;
    logic [DW-1:0]    popped;

    always @(negedge clk) begin
        if (!reset) begin
            prev_rd_en = '0;
        end else begin
            for (int k = 0; k < WH; k++) begin
                x_wen[k]           = log_ok(n_edge - k) ? w_act_log[n_edge - k] : 1'b0;
                x_ren[k]           = log_ok(n_edge - k) ? r_act_log[n_edge - k] : 1'b0;
                x_wad[k*AW +: AW]  = log_ok(n_edge - k) ? AW'(w_row_log[n_edge - k]) : '0;
                x_rad[k*AW +: AW]  = log_ok(n_edge - k) ? AW'(r_row_log[n_edge - k]) : '0;
                x_rd[k*DW +: DW]   = exp_rd[k];
            end
            check("wr_en",   128'(wr_en),   128'(x_wen));
            check("rd_en",   128'(rd_en),   128'(x_ren));
            check("wr_addr", wr_addr,       x_wad);
            check("rd_addr", rd_addr,       x_rad);
            check("rd_hold", rd_data,       x_rd);
            // a read issued at the last edge presents its data now
            for (int k = 0; k < WH; k++) begin
                if (prev_rd_en[k]) begin
                    if (rdq[k].size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL rd_pop lane %0d: got unexpected read, expected none", k);
                    end else begin
                        popped = rdq[k].pop_front();
                        check("rd_data_lane", 128'(rd_data[k*DW +: DW]), 128'(popped));
                    end
                end
            end
            prev_rd_en = rd_en;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) step();
        reset = 1'b1;
        repeat (2) step();

        // write phase: lane k row r lands on edge k+r+2 of this loop
        for (int c = 1; c <= 34; c++) begin
            wr_active = (c <= 16);
            for (int k = 0; k < WH; k++) begin
                if ((c - 2 - k) >= 0 && (c - 2 - k) < WH)
                    wr_data[k*DW +: DW] = DW'(16 * k + (c - 2 - k));
                else
                    wr_data[k*DW +: DW] = '0;
            end
            step();
        end

        // read phase: last read on each lane returns row 15
        for (int c = 1; c <= 34; c++) begin
            rd_active = (c <= 16);
            step();
        end
        for (int k = 0; k < WH; k++)
            check("roundtrip_row15", 128'(rd_data[k*DW +: DW]), 128'(16 * k + 15));

        // wrap: 20 active cycles
        rd_active = 1'b1;
        repeat (20) step();
        rd_active = 1'b0;
        repeat (20) step();

        // counter restart: 5 on, 2 off, 5 on
        wr_data   = {4{$urandom}};
        wr_active = 1'b1;
        repeat (5) step();
        wr_active = 1'b0;
        repeat (2) step();
        wr_active = 1'b1;
        repeat (5) step();
        wr_active = 1'b0;
        repeat (20) step();

        // read-first collision on lane 0 address 0
        wr_data[DW-1:0] = 8'hAA;
        wr_active = 1'b1;
        step();
        wr_active = 1'b0;
        repeat (2) step();
        wr_data[DW-1:0] = 8'h55;
        wr_active = 1'b1;
        rd_active = 1'b1;
        step();
        wr_active = 1'b0;
        rd_active = 1'b0;
        step();
        check("collide_old", 128'(rd_data[DW-1:0]), 128'(8'hAA));
        step();
        rd_active = 1'b1;
        step();
        rd_active = 1'b0;
        step();
        check("collide_new", 128'(rd_data[DW-1:0]), 128'(8'h55));
        repeat (20) step();

        // randomized traffic with an asynchronous reset mid-stream
        for (int i = 0; i < 300; i++) begin
            wr_active = ($urandom_range(0, 3) != 0);
            rd_active = ($urandom_range(0, 3) != 0);
            wr_data   = {$urandom, $urandom, $urandom, $urandom};
            if (i == 150) begin
                @(negedge clk);
                #2;
                reset = 1'b0;
                #1;
                check("rst_wr_en",   128'(wr_en), 128'(0));
                check("rst_rd_en",   128'(rd_en), 128'(0));
                check("rst_wr_addr", wr_addr,     128'(0));
                check("rst_rd_addr", rd_addr,     128'(0));
                check("rst_rd_data", rd_data,     128'(0));
                repeat (2) step();
                reset = 1'b1;
            end
            step();
        end

        wr_active = 1'b0;
        rd_active = 1'b0;
        repeat (40) step();
        for (int k = 0; k < WH; k++)
            check("rdq_empty", 128'(rdq[k].size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
